// File: rtl/ysyx_22050133_mdu.sv
// Iterative RV64 M-extension multiply/divide unit: one bit per cycle in CALC,
// with sign handling in PREP/FIX and a fast path for divide special cases.
module ysyx_22050133_mdu #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              word_q, word_d;
    logic [XLEN-1:0]   src1_q, src1_d, src2_q, src2_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   quot_q, quot_d, rem_q, rem_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div, w_eff, a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs, min_neg;
    logic [XLEN:0]     mul_sum, div_tmp;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_p, mul_r;
    logic [XLEN-1:0]   q_fix, r_fix, res_sel, res_fix;
    logic [5:0]        n_last;

    // Operand decode is derived from the latched request, so PREP and FIX see identical signs.
    always_comb begin
        is_div = op_q[2];
        w_eff  = word_q & (is_div | (op_q == 3'd0));
        a_sgn  = (op_q == 3'd1) | (op_q == 3'd2) | (op_q == 3'd4) | (op_q == 3'd6);
        b_sgn  = (op_q == 3'd1) | (op_q == 3'd4) | (op_q == 3'd6);
        if (w_eff) begin
            a_ext   = {{(XLEN-32){a_sgn & src1_q[31]}}, src1_q[31:0]};
            b_ext   = {{(XLEN-32){b_sgn & src2_q[31]}}, src2_q[31:0]};
            min_neg = {{(XLEN-31){1'b1}}, 31'b0};
        end else begin
            a_ext   = src1_q;
            b_ext   = src2_q;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg  = a_sgn & a_ext[XLEN-1];
        b_neg  = b_sgn & b_ext[XLEN-1];
        a_abs  = a_neg ? -a_ext : a_ext;
        b_abs  = b_neg ? -b_ext : b_ext;
        div0   = is_div & (b_ext == '0);
        ovf    = is_div & b_sgn & (a_ext == min_neg) & (b_ext == '1);
        n_last = w_eff ? 6'd31 : 6'd63;
    end

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
        div_tmp  = {rem_q, quot_q[XLEN-1]};
        div_ge   = div_tmp >= {1'b0, opnd_q};
        div_diff = div_tmp[XLEN-1:0] - opnd_q;

        // A 32-bit multiply stops after 32 right shifts, leaving the product 32 bits high.
        mul_p = w_eff ? (prod_q >> 32) : prod_q;
        mul_r = (a_neg ^ b_neg) ? -mul_p : mul_p;
        if (div0) begin
            q_fix = '1;
            r_fix = a_ext;
        end else if (ovf) begin
            q_fix = a_ext;
            r_fix = '0;
        end else begin
            q_fix = (a_neg ^ b_neg) ? -quot_q : quot_q;
            r_fix = a_neg ? -rem_q : rem_q;
        end
        case (op_q)
            3'd0:                res_sel = mul_r[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    res_sel = mul_r[2*XLEN-1:XLEN];
            3'd4, 3'd5:          res_sel = q_fix;
            default:             res_sel = r_fix;
        endcase
        res_fix = w_eff ? {{(XLEN-32){res_sel[31]}}, res_sel[31:0]} : res_sel;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        word_d   = word_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_PREP;
                    op_d    = op;
                    word_d  = word;
                    src1_d  = src1;
                    src2_d  = src2;
                end
            end
            S_PREP: begin
                cnt_d   = '0;
                opnd_d  = is_div ? b_abs : a_abs;
                prod_d  = {{XLEN{1'b0}}, b_abs};
                quot_d  = w_eff ? (a_abs << 32) : a_abs;
                rem_d   = '0;
                state_d = (div0 | ovf) ? S_FIX : S_CALC;
            end
            S_CALC: begin
                if (is_div) begin
                    rem_d  = div_ge ? div_diff : div_tmp[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], div_ge};
                end else begin
                    prod_d = {mul_sum, prod_q[XLEN-1:1]};
                end
                if (cnt_q == n_last) state_d = S_FIX;
                else                 cnt_d   = cnt_q + 6'd1;
            end
            S_FIX: begin
                result_d = res_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            word_q   <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22050133_mdu.sv
// Directed-vector bench for the iterative multiply/divide unit: results,
// fixed latencies, output hold, flush and reset behaviour.
module tb_ysyx_22050133_mdu;

    logic        clk = 1'b0;
    logic        rst, in_valid, word, flush, out_ready;
    logic [2:0]  op;
    logic [63:0] src1, src2;
    logic        in_ready, out_valid, busy;
    logic [63:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_22050133_mdu #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .word      (word),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Called 1 time unit after an edge; returns having accepted on the next edge.
    task automatic start_op(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        op       = o;
        word     = w;
        src1     = a;
        src2     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the one right after the acceptance edge; 0 means no out_valid seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int c = 1; c <= 150; c++) begin
            if (out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
        int lat;
        start_op(o, w, a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check(tag, result, exp_res);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1; in_valid = 1'b0; word = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = 3'd0; src1 = '0; src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    result,         64'd0);
        rst = 1'b0;

        run("div_m7_2",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67);
        run("rem_m7_2",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        run("divu_by0",    3'd5, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        run("remu_by0",    3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 3);
        run("divw_ovf",    3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 3);
        run("remw_ovf",    3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 3);
        run("div_ovf64",   3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 3);
        run("remw_by0",    3'd6, 1'b1, 64'h8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, 3);
        run("mulhu_max",   3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE, 67);
        run("mulhu_wign",  3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE, 67);
        run("mulh_m1m1",   3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 67);
        run("mulhsu_m1_2", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        run("mulw_7fff_2", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35);
        run("mul_3_m5",    3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 67);
        run("divw_m7_2",   3'd4, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 35);
        run("remuw_100_7", 3'd7, 1'b1, 64'd100, 64'd7, 64'd2, 35);

        // Result must hold while the consumer stalls.
        out_ready = 1'b0;
        start_op(3'd5, 1'b0, 64'd100, 64'd7);
        wait_valid(lat);
        check("hold_lat", 64'(lat), 64'd67);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", result, 64'd14);
            check("hold_busy", 64'(busy), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_no_accept", 64'(busy), 64'd0);

        // Flush in CALC cycle 20 (cycle 21 after acceptance).
        start_op(3'd5, 1'b0, 64'd1000, 64'd3);
        repeat (20) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        run("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 67);

        // Reset mid-CALC.
        start_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        repeat (30) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstcalc_in_ready", 64'(in_ready), 64'd1);
        check("rstcalc_busy", 64'(busy), 64'd0);
        check("rstcalc_out_valid", 64'(out_valid), 64'd0);
        check("rstcalc_result", result, 64'd0);

        // Reset in DONE.
        out_ready = 1'b0;
        start_op(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2);
        wait_valid(lat);
        check("rstdone_lat", 64'(lat), 64'd35);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstdone_out_valid", 64'(out_valid), 64'd0);
        check("rstdone_result", result, 64'd0);
        check("rstdone_in_ready", 64'(in_ready), 64'd1);

        // Reset wins over flush, out_ready and a new request.
        start_op(3'd5, 1'b0, 64'h1234, 64'd0);
        wait_valid(lat);
        check("rstflush_lat", 64'(lat), 64'd3);
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check("rstflush_result", result, 64'd0);
        check("rstflush_out_valid", 64'(out_valid), 64'd0);
        check("rstflush_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
